// File: rtl/rx_arb_pkg.sv
// Shared constants for the RX FIFO arbiter: FSM encoding,
// hit-frame word index field and the frame-end detector.
package rx_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  localparam int         FRAME_IDX_LSB = 28;
  localparam logic [1:0] FRAME_END_IDX = 2'b10;

  localparam int TO_CNT_W = 8;

  function automatic logic is_frame_end(
    input logic [1:0] idx
  );
    return idx == FRAME_END_IDX;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first requester after i_ptr wins.
// Ports: i_req, i_ptr in; o_grant (one-hot), o_idx, o_valid out.
module rr_priority_pick #(
  parameter int N_SRC = 4,
  parameter int IW    = 2
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_SRC-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  logic [IW-1:0] w_j;

  // Scan farthest to nearest so the nearest requester
  // after the pointer is the last (winning) assignment.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N_SRC);
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin merge of N source FIFOs into one output FIFO with
// frame-aware grant hold, empty-cycle timeout and 1-word out reg.
// Ports: BUS_CLK/BUS_RST; CONF_* config; SRC_FIFO_* per-source
// FWFT side; OUT_FIFO_* downstream; GRANT, TIMEOUT_CNT status.
module rx_fifo_arbiter
  import rx_arb_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int TO_WIDTH = 8
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic [N_SRC-1:0]      CONF_SRC_EN,
  input  logic [N_SRC-1:0]      CONF_HOLD_FRAME,
  input  logic [TO_WIDTH-1:0]   CONF_TIMEOUT,
  input  logic [N_SRC-1:0]      SRC_FIFO_EMPTY,
  output logic [N_SRC-1:0]      SRC_FIFO_READ,
  input  logic [32*N_SRC-1:0]   SRC_FIFO_DATA,
  input  logic                  OUT_FIFO_FULL,
  output logic                  OUT_FIFO_WRITE,
  output logic [31:0]           OUT_FIFO_DATA,
  output logic [N_SRC-1:0]      GRANT,
  output logic [TO_CNT_W-1:0]   TIMEOUT_CNT
);

  localparam int IW = $clog2(N_SRC);

  logic                r_state;
  logic [N_SRC-1:0]    r_grant;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_ptr;
  logic                r_out_valid;
  logic [31:0]         r_out_data;
  logic [TO_WIDTH-1:0] r_ecnt;
  logic [TO_CNT_W-1:0] r_to_cnt;

  logic [N_SRC-1:0]    w_req;
  logic [N_SRC-1:0]    w_pick_grant;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_valid;
  logic                w_pop_ok;
  logic [N_SRC-1:0]    w_read;
  logic                w_pop;
  logic [31:0]         w_pop_data;
  logic                w_g_en;
  logic                w_g_empty;
  logic                w_g_hold;
  logic                w_end;
  logic [TO_WIDTH-1:0] w_ecnt_nxt;
  logic                w_tmo;
  logic [31:0]         w_src_data [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_data
    assign w_src_data[i] = SRC_FIFO_DATA[32*i +: 32];
  end

  assign w_req = CONF_SRC_EN & ~SRC_FIFO_EMPTY;

  rr_priority_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_pop_ok  = ~r_out_valid | ~OUT_FIFO_FULL;
  assign w_g_en    = |(r_grant & CONF_SRC_EN);
  assign w_g_empty = |(r_grant & SRC_FIFO_EMPTY);
  assign w_g_hold  = |(r_grant & CONF_HOLD_FRAME);

  assign w_read = (r_state == ST_XFER && w_pop_ok)
                ? (r_grant & ~SRC_FIFO_EMPTY & CONF_SRC_EN)
                : '0;
  assign w_pop      = |w_read;
  assign w_pop_data = w_src_data[r_gidx];
  assign w_end      = is_frame_end(
                        w_pop_data[FRAME_IDX_LSB +: 2]);

  // Release at the edge that closes the N-th empty cycle.
  assign w_ecnt_nxt = r_ecnt + TO_WIDTH'(1);
  assign w_tmo      = (CONF_TIMEOUT != '0) &&
                      (w_ecnt_nxt == CONF_TIMEOUT);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_ptr    <= IW'(N_SRC - 1);
      r_ecnt   <= '0;
      r_to_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_ecnt <= '0;
          if (w_pick_valid) begin
            r_state <= ST_XFER;
            r_grant <= w_pick_grant;
            r_gidx  <= w_pick_idx;
            r_ptr   <= w_pick_idx;
          end
        end
        ST_XFER: begin
          if (!w_g_en) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ecnt  <= '0;
          end else if (w_pop) begin
            r_ecnt <= '0;
            if (!w_g_hold || w_end) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
            end
          end else if (w_g_empty && w_g_hold) begin
            if (w_tmo) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_ecnt  <= '0;
              if (r_to_cnt != '1)
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
              r_ecnt <= w_ecnt_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Data holds while full; valid drops once written.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pop_data;
    end else if (!OUT_FIFO_FULL) begin
      r_out_valid <= 1'b0;
    end
  end

  assign SRC_FIFO_READ  = w_read;
  assign OUT_FIFO_WRITE = r_out_valid & ~OUT_FIFO_FULL;
  assign OUT_FIFO_DATA  = r_out_data;
  assign GRANT          = r_grant;
  assign TIMEOUT_CNT    = r_to_cnt;

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Bench for rx_fifo_arbiter: queue-backed FWFT sources and a
// frame-level round-robin model predicting the output order.
module tb_rx_fifo_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    en = '1;
  logic [N-1:0]    hold = '1;
  logic [7:0]      tmo = '0;
  logic [N-1:0]    empty = '1;
  logic [N-1:0]    rd;
  logic [32*N-1:0] sdata = '0;
  logic            full = 1'b0;
  logic            wr;
  logic [31:0]     odata;
  logic [N-1:0]    grant;
  logic [7:0]      tocnt;

  rx_fifo_arbiter #(
    .N_SRC    (N),
    .TO_WIDTH (8)
  ) dut (
    .BUS_CLK         (clk),
    .BUS_RST         (rst),
    .CONF_SRC_EN     (en),
    .CONF_HOLD_FRAME (hold),
    .CONF_TIMEOUT    (tmo),
    .SRC_FIFO_EMPTY  (empty),
    .SRC_FIFO_READ   (rd),
    .SRC_FIFO_DATA   (sdata),
    .OUT_FIFO_FULL   (full),
    .OUT_FIFO_WRITE  (wr),
    .OUT_FIFO_DATA   (odata),
    .GRANT           (grant),
    .TIMEOUT_CNT     (tocnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  int cyc   = 0;

  logic [31:0] q [N][$];
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];

  logic [N-1:0] s_grant, s_empty, s_read;
  logic [31:0]  s_data;
  logic         s_write;

  function automatic logic [31:0] mkw(int src, int idx);
    logic [23:0] p;
    p = 24'($urandom);
    return {2'b00, 2'(idx), 4'(src), p};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      empty[i] = (q[i].size() == 0);
      sdata[32*i +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
    end
  endtask

  task automatic push_frame(int s);
    for (int k = 0; k < 3; k++) q[s].push_back(mkw(s, k));
  endtask

  // Sample at negedge, then apply pops/writes after the edge.
  task automatic step();
    @(negedge clk);
    s_grant = grant;
    s_empty = empty;
    s_read  = rd;
    s_data  = odata;
    s_write = wr;
    if (s_read != 0 && !$onehot(s_read)) viol++;
    for (int i = 0; i < N; i++)
      if (s_read[i] && (s_empty[i] || q[i].size() == 0)) viol++;
    @(posedge clk);
    #1;
    cyc++;
    if (s_write) begin
      got.push_back(s_data);
      got_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++)
      if (s_read[i] && q[i].size() != 0) void'(q[i].pop_front());
    drive();
  endtask

  task automatic run_until(int n, int budget);
    int b;
    b = budget;
    while (got.size() < n && b > 0) begin
      step();
      b--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    full = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got.delete();
    got_cyc.delete();
    cyc = 0;
  endtask

  // Frame-level reference: pick next requester after ptr, take a
  // whole frame (hold) or a single word, repeat until all drained.
  task automatic model_run(input logic [N-1:0] h,
                           input logic [N-1:0] e);
    logic [31:0] mq [N][$];
    logic [31:0] w;
    int ptr, j;
    bit found;
    exp_q.delete();
    for (int i = 0; i < N; i++) mq[i] = q[i];
    ptr = N - 1;
    while (1) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        j = (ptr + k) % N;
        if (!found && e[j] && mq[j].size() > 0) begin
          found = 1;
          ptr = j;
        end
      end
      if (!found) break;
      do begin
        w = mq[ptr].pop_front();
        exp_q.push_back(w);
      end while (h[ptr] && w[29:28] != 2'b10 &&
                 mq[ptr].size() > 0);
    end
  endtask

  task automatic test_reset();
    en = '1; hold = '1; tmo = '0;
    do_reset();
    step();
    tests++;
    if (s_grant !== '0) begin
      fails++; $display("FAIL reset_grant got %h exp 0", s_grant);
    end
    tests++;
    if (s_read !== '0) begin
      fails++; $display("FAIL reset_read got %h exp 0", s_read);
    end
    tests++;
    if (s_write !== 1'b0) begin
      fails++; $display("FAIL reset_write got %b exp 0", s_write);
    end
    tests++;
    if (s_data !== 32'h0) begin
      fails++; $display("FAIL reset_data got %h exp 0", s_data);
    end
    tests++;
    if (tocnt !== 8'h0) begin
      fails++; $display("FAIL reset_tocnt got %0d exp 0", tocnt);
    end
  endtask

  task automatic test_frames();
    en = '1; hold = '1; tmo = '0;
    do_reset();
    push_frame(2);
    push_frame(0);
    drive();
    model_run(hold, en);
    run_until(6, 60);
    tests++;
    if (got.size() !== 6) begin
      fails++; $display("FAIL frames_count got %0d exp 6", got.size());
    end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      tests++;
      if (got[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL frames_w%0d got %h exp %h", k, got[k], exp_q[k]);
      end
    end
    if (got.size() == 6) begin
      tests++;
      if (got_cyc[1] - got_cyc[0] != 1 ||
          got_cyc[2] - got_cyc[1] != 1 ||
          got_cyc[3] - got_cyc[2] < 2) begin
        fails++;
        $display("FAIL frames_gap got %0d,%0d,%0d exp 1,1,>=2",
                 got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1],
                 got_cyc[3] - got_cyc[2]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    en = '1; hold = '0; tmo = '0;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = N - 1; s >= 0; s--)
        q[s].push_back(mkw(s, $urandom_range(0, 3)));
    drive();
    model_run(hold, en);
    run_until(8, 80);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (k >= got.size() || got[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL rr_w%0d got %h exp %h (src %0d)", k,
                 (k < got.size()) ? got[k] : 32'hx, exp_q[k], k % N);
      end
    end
  endtask

  task automatic test_random();
    int b, n;
    for (int it = 0; it < 4; it++) begin
      en = '1;
      hold = N'($urandom);
      tmo = '0;
      do_reset();
      for (int s = 0; s < N; s++) begin
        n = $urandom_range(0, 3);
        for (int f = 0; f < n; f++) begin
          if (hold[s]) push_frame(s);
          else
            for (int w = $urandom_range(1, 3); w > 0; w--)
              q[s].push_back(mkw(s, $urandom_range(0, 3)));
        end
      end
      drive();
      model_run(hold, en);
      b = 600;
      while (got.size() < exp_q.size() && b > 0) begin
        full = ($urandom_range(0, 3) == 0);
        step();
        b--;
      end
      full = 1'b0;
      repeat (4) step();
      tests++;
      if (got != exp_q) begin
        fails++;
        $display("FAIL random_seq%0d got %0d words exp %0d hold %b",
                 it, got.size(), exp_q.size(), hold);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] f [3];
    int ec;
    en = '1; hold = '1; tmo = 8'd5;
    do_reset();
    for (int k = 0; k < 3; k++) f[k] = mkw(1, k);
    q[1].push_back(f[0]);
    q[1].push_back(f[1]);
    drive();
    ec = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_grant == 4'b0010 && s_empty[1]) ec++;
    end
    tests++;
    if (ec !== 5) begin
      fails++; $display("FAIL timeout_empty_cycles got %0d exp 5", ec);
    end
    tests++;
    if (tocnt !== 8'd1) begin
      fails++; $display("FAIL timeout_cnt got %0d exp 1", tocnt);
    end
    q[1].push_back(f[2]);
    drive();
    run_until(3, 30);
    tests++;
    if (got.size() !== 3 || got[2] !== f[2]) begin
      fails++;
      $display("FAIL timeout_late_word got %0d words exp %h",
               got.size(), f[2]);
    end
    tests++;
    if (tocnt !== 8'd1) begin
      fails++; $display("FAIL timeout_cnt_after got %0d exp 1", tocnt);
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] f [$];
    logic [31:0] d0;
    int bad;
    en = '1; hold = '1; tmo = 8'd3;
    do_reset();
    push_frame(0);
    f = q[0];
    drive();
    run_until(1, 20);
    full = 1'b1;
    bad = 0;
    step();
    d0 = s_data;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      if (s_read != '0 || s_data !== d0 || s_write) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL full_hold got %0d bad cycles exp 0", bad);
    end
    tests++;
    if (tocnt !== 8'd0 || grant !== 4'b0001) begin
      fails++;
      $display("FAIL full_grant got cnt %0d grant %b exp 0 0001",
               tocnt, grant);
    end
    full = 1'b0;
    run_until(3, 20);
    tests++;
    if (got != f) begin
      fails++;
      $display("FAIL full_frame got %0d words exp 3 intact", got.size());
    end
  endtask

  task automatic test_enable();
    bit seen;
    int b;
    en = 4'b1101; hold = '1; tmo = '0;
    do_reset();
    push_frame(1);
    drive();
    seen = 0;
    repeat (15) begin
      step();
      if (s_grant[1]) seen = 1;
    end
    tests++;
    if (seen || got.size() != 0 || q[1].size() != 3) begin
      fails++;
      $display("FAIL en_masked got seen %0d words %0d exp 0 0",
               seen, got.size());
    end
    en = '1;
    b = 20;
    while (q[1].size() > 1 && b > 0) begin
      step();
      b--;
    end
    en = 4'b1101;
    step();
    tests++;
    if (s_read !== '0) begin
      fails++; $display("FAIL en_clear_read got %b exp 0", s_read);
    end
    step();
    tests++;
    if (s_grant !== '0) begin
      fails++; $display("FAIL en_clear_grant got %b exp 0", s_grant);
    end
    repeat (3) step();
    tests++;
    if (q[1].size() !== 1 || tocnt !== 8'd0) begin
      fails++;
      $display("FAIL en_clear_after got left %0d cnt %0d exp 1 0",
               q[1].size(), tocnt);
    end
  endtask

  task automatic test_async_reset();
    en = '1; hold = '1; tmo = '0;
    do_reset();
    push_frame(0);
    push_frame(1);
    drive();
    run_until(1, 20);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (grant !== '0 || rd !== '0 || wr !== 1'b0) begin
      fails++;
      $display("FAIL async_rst got g %b r %b w %b exp 0 0 0",
               grant, rd, wr);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    push_frame(1);
    push_frame(0);
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got.delete();
    got_cyc.delete();
    model_run(hold, en);
    run_until(6, 60);
    tests++;
    if (got.size() == 0 || got[0][27:24] !== 4'd0) begin
      fails++;
      $display("FAIL async_first_src got %0d words exp src0 first",
               got.size());
    end
    tests++;
    if (got != exp_q) begin
      fails++;
      $display("FAIL async_seq got %0d words exp %0d",
               got.size(), exp_q.size());
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL read_protocol got %0d exp 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_rr_wrap();
    test_random();
    test_timeout();
    test_full_stall();
    test_enable();
    test_async_reset();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_fifo_arbiter.md
Name: rx_fifo_arbiter

Overview:
- Merges the 32-bit output FIFOs of N receiver cores (tjmono data RX, timestamp, TLU) into the single readout FIFO on BUS_CLK.
- Arbitration is round-robin with frame-aware grant hold. A 3-word hit frame from a data RX core (word index in bits [29:28]: 00, 01, 10) is never interleaved with words from another source.
- A timeout releases a stalled grant.
- The block sits between the per-core FIFO_READ/FIFO_EMPTY/FIFO_DATA ports and the top-level output FIFO.

Parameters:
- N_SRC, 4, number of source FIFOs (2..8).
- TO_WIDTH, 8, width of the frame-timeout configuration and counter.

Ports:
- BUS_CLK  in  1  clock.
- BUS_RST  in  1  asynchronous active-high reset.
- CONF_SRC_EN  in  N_SRC  per-source enable mask.
- CONF_HOLD_FRAME  in  N_SRC  per-source enable for frame hold.
- CONF_TIMEOUT  in  TO_WIDTH  max consecutive empty cycles inside a held frame; 0 disables the timeout.
- SRC_FIFO_EMPTY  in  N_SRC  source empty flags. Sources are first-word-fall-through: data is valid whenever the flag is low.
- SRC_FIFO_READ  out  N_SRC  pop strobes, one-hot or zero.
- SRC_FIFO_DATA  in  32*N_SRC  source data, source i at [32*i+31:32*i].
- OUT_FIFO_FULL  in  1  downstream full.
- OUT_FIFO_WRITE  out  1  downstream write strobe.
- OUT_FIFO_DATA  out  32  downstream data.
- GRANT  out  N_SRC  one-hot current grant, zero when idle.
- TIMEOUT_CNT  out  8  saturating count of timeout releases.

Behaviour:
- Clock and reset: one clock, BUS_CLK. BUS_RST is asynchronous and active-high.
- Reset values:
  - state = IDLE, GRANT = 0, SRC_FIFO_READ = 0.
  - Output register empty (out_valid = 0), OUT_FIFO_WRITE = 0, OUT_FIFO_DATA = 0.
  - TIMEOUT_CNT = 0, round-robin pointer = N_SRC-1 (source 0 wins first), empty-cycle counter = 0.
- Request: req[i] = CONF_SRC_EN[i] & ~SRC_FIFO_EMPTY[i].
- Output stage is a single register:
  - OUT_FIFO_WRITE = out_valid & ~OUT_FIFO_FULL. OUT_FIFO_DATA holds its value while full.
  - A pop is allowed when (~out_valid | ~OUT_FIFO_FULL).
  - A popped word appears on OUT_FIFO_DATA with out_valid one cycle after SRC_FIFO_READ.
  - Sustained throughput is 1 word/cycle within a grant.
- IDLE state:
  - If any req: grant the first requester searching ptr+1, ptr+2, … with wrap modulo N_SRC. Go to XFER, GRANT one-hot registered, ptr <= granted index.
  - No pop in the arbitration cycle.
  - No req: stay in IDLE.
- XFER state:
  - SRC_FIFO_READ[g] = GRANT[g] & ~SRC_FIFO_EMPTY[g] & CONF_SRC_EN[g] & pop-allowed. This is combinational from registered grant.
  - On a pop:
    - If CONF_HOLD_FRAME[g] = 0, release after this word.
    - If CONF_HOLD_FRAME[g] = 1, release only after popping a word with data[29:28] = FRAME_END_IDX (2'b10).
    - Release means: next state IDLE, GRANT <= 0.
  - The empty-cycle counter resets on every pop.
  - Granted source empty while hold is pending: the counter increments each cycle.
    - When counter == CONF_TIMEOUT and CONF_TIMEOUT != 0, release to IDLE.
    - On that release, TIMEOUT_CNT increments, saturating at 255.
    - CONF_TIMEOUT = 0 holds indefinitely.
  - OUT_FIFO_FULL stalls do not count as empty cycles.
  - CONF_SRC_EN[g] deasserted while in XFER: no further pops; release at the next edge; TIMEOUT_CNT unchanged.
- Boundary conditions:
  - Downstream full with out_valid = 1: no pop, out register held, grant held.
  - Simultaneous release and new requests: IDLE always takes one cycle, so consecutive frames are separated by ≥1 bubble.
  - Pointer wrap from N_SRC-1 to 0 is required.
  - Reset asserted mid-frame: all state clears immediately. The word in the out register is discarded (no write).
  - Exactly one SRC_FIFO_READ bit is ever high, and only when the corresponding EMPTY is low.

Decomposition:
- Package rx_arb_pkg:
  - State encoding: IDLE = 1'b0, XFER = 1'b1.
  - FRAME_IDX_LSB = 28, FRAME_END_IDX = 2'b10.
- Sub-module rr_priority_pick: combinational rotate-priority encoder.
  - Inputs: req[N_SRC-1:0], ptr.
  - Outputs: one-hot grant, index, valid.
- The FSM, output register and counters stay in the top module.

Test Plan:
1. Sources 0 and 2 each hold one 3-word frame (idx 00,01,10), hold enabled, no full -> out order src0 w0,w1,w2 then src2 w0,w1,w2; no interleaving; one idle cycle between the frames.
2. Hold disabled, sources 0..3 each with 2 single words -> out order 0,1,2,3,0,1,2,3; ptr wraps 3->0.
3. src1 frame: 2 words present, third arrives 20 cycles later, CONF_TIMEOUT = 5 -> release after 5 empty cycles, TIMEOUT_CNT = 1. The late word is then taken as a new grant.
4. OUT_FIFO_FULL high for 10 cycles mid-frame -> OUT_FIFO_DATA stable, no SRC_FIFO_READ, TIMEOUT_CNT unchanged; the frame completes intact after full drops.
5. CONF_SRC_EN[1] = 0 with src1 non-empty -> never granted; clear it mid-frame -> pops stop, GRANT = 0 next cycle.
6. BUS_RST pulsed asynchronously mid-frame -> GRANT, SRC_FIFO_READ and OUT_FIFO_WRITE are 0 immediately; after release source 0 is granted first.
